i2c_ball_tx_scheduler: RTL

Sequences the byte-level I2C master that hands ball state to the opposing player's board. When the game controller signals that the ball has left the local screen, this block snapshots the ball registers and issues START, address, six data bytes and STOP as single commands. It handles NACK and timeout with bounded retries, and queues one request that arrives while a transfer is in flight. It sits between the game controller and the I2C master, in place of the free-running register export.

---
 rtl/i2c_ball_tx_scheduler.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/i2c_ball_tx_scheduler.sv
// Ball-handoff scheduler: snapshots ball state and drives START / address / six data bytes / STOP
// into a byte-level I2C master, with bounded retries on NACK or timeout and a single queued request.
module i2c_ball_tx_scheduler #(
    parameter logic [6:0] SLAVE_ADDR = 7'h42,
    parameter int         MAX_TRIES  = 3,
    parameter int         TIMEOUT    = 50000,
    parameter int         GAP        = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       send_req,
    input  logic [9:0] ball_y,
    input  logic [7:0] ball_vy,
    input  logic [7:0] gravity,
    input  logic [7:0] ball_speed,
    input  logic [7:0] win_flag,
    output logic       m_valid,
    output logic [1:0] m_cmd,
    output logic [7:0] m_data,
    input  logic       m_ready,
    input  logic       m_done,
    input  logic       m_nack,
    output logic       busy,
    output logic       pending,
    output logic       tx_done,
    output logic       tx_error,
    output logic [2:0] try_cnt
);

    localparam logic [1:0] CMD_START = 2'd0;
    localparam logic [1:0] CMD_WRITE = 2'd1;
    localparam logic [1:0] CMD_STOP  = 2'd2;
    localparam logic [2:0] LAST_IDX  = 3'd6;
    localparam logic [7:0] ADDR_BYTE = {SLAVE_ADDR, 1'b0};

    localparam int TW = ($clog2(TIMEOUT) > 17) ? $clog2(TIMEOUT) : 17;
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP - 1);
    localparam logic [2:0]    TRY_LAST = 3'(MAX_TRIES);

    typedef enum logic [1:0] {S_IDLE, S_CMD, S_WAIT, S_RETRY} state_t;

    state_t         r_state;
    logic           r_valid;
    logic [1:0]     r_cmd;
    logic [7:0]     r_data;
    logic           r_busy;
    logic           r_pending;
    logic           r_tx_done;
    logic           r_tx_error;
    logic [2:0]     r_try;
    logic [2:0]     r_idx;
    logic           r_fail;
    logic [TW-1:0]  r_tmo;
    logic [GW-1:0]  r_gap;
    logic [9:0]     r_y;
    logic [7:0]     r_vy;
    logic [7:0]     r_grav;
    logic [7:0]     r_speed;
    logic [7:0]     r_win;

    logic           w_tmo_hit;
    logic           w_stop_end;
    logic           w_stop_ok;
    logic [2:0]     w_idx_nxt;
    logic [7:0]     w_byte_nxt;

    // Index 0 is the address byte; 1..6 are the snapshot payload bytes.
    function automatic logic [7:0] f_byte(input logic [2:0] idx, input logic [9:0] y,
                                          input logic [7:0] vy, input logic [7:0] grav,
                                          input logic [7:0] speed, input logic [7:0] win);
        logic [7:0] b;
        case (idx)
            3'd0:    b = ADDR_BYTE;
            3'd1:    b = y[7:0];
            3'd2:    b = {6'b0, y[9:8]};
            3'd3:    b = vy;
            3'd4:    b = grav;
            3'd5:    b = speed;
            3'd6:    b = win;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    assign w_tmo_hit  = (r_tmo == TMO_LAST);
    assign w_stop_end = (r_state == S_WAIT) && (r_cmd == CMD_STOP) && (m_done || w_tmo_hit);
    assign w_stop_ok  = m_done && !r_fail;
    assign w_idx_nxt  = r_idx + 3'd1;
    assign w_byte_nxt = f_byte(w_idx_nxt, r_y, r_vy, r_grav, r_speed, r_win);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_valid    <= 1'b0;
            r_cmd      <= CMD_START;
            r_data     <= 8'h00;
            r_busy     <= 1'b0;
            r_pending  <= 1'b0;
            r_tx_done  <= 1'b0;
            r_tx_error <= 1'b0;
            r_try      <= 3'd0;
            r_idx      <= 3'd0;
            r_fail     <= 1'b0;
            r_tmo      <= '0;
            r_gap      <= '0;
            r_y        <= 10'd0;
            r_vy       <= 8'h00;
            r_grav     <= 8'h00;
            r_speed    <= 8'h00;
            r_win      <= 8'h00;
        end else begin
            r_tx_done  <= 1'b0;
            r_tx_error <= 1'b0;
            // Any number of requests during a frame collapse into one queued frame.
            if (send_req && (r_state != S_IDLE))
                r_pending <= 1'b1;

            case (r_state)
                S_IDLE: begin
                    if (send_req || r_pending) begin
                        r_y       <= ball_y;
                        r_vy      <= ball_vy;
                        r_grav    <= gravity;
                        r_speed   <= ball_speed;
                        r_win     <= win_flag;
                        r_try     <= 3'd1;
                        r_pending <= 1'b0;
                        r_fail    <= 1'b0;
                        r_busy    <= 1'b1;
                        r_state   <= S_CMD;
                        r_valid   <= 1'b1;
                        r_cmd     <= CMD_START;
                        r_data    <= 8'h00;
                    end
                end
                S_CMD: begin
                    if (m_ready) begin
                        r_valid <= 1'b0;
                        r_tmo   <= '0;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (w_stop_end) begin
                        // End of an attempt: success, give up, or back off and retry.
                        if (w_stop_ok || (r_try >= TRY_LAST)) begin
                            r_tx_done  <= w_stop_ok;
                            r_tx_error <= !w_stop_ok;
                            r_state    <= S_IDLE;
                            r_busy     <= 1'b0;
                            r_try      <= 3'd0;
                            r_fail     <= 1'b0;
                            r_cmd      <= CMD_START;
                            r_data     <= 8'h00;
                        end else begin
                            r_fail  <= 1'b1;
                            r_gap   <= '0;
                            r_state <= S_RETRY;
                        end
                    end else if (m_done) begin
                        r_state <= S_CMD;
                        r_valid <= 1'b1;
                        if (r_cmd == CMD_START) begin
                            r_idx  <= 3'd0;
                            r_cmd  <= CMD_WRITE;
                            r_data <= ADDR_BYTE;
                        end else if (m_nack || (r_idx == LAST_IDX)) begin
                            if (m_nack)
                                r_fail <= 1'b1;
                            r_cmd  <= CMD_STOP;
                            r_data <= 8'h00;
                        end else begin
                            r_idx  <= w_idx_nxt;
                            r_data <= w_byte_nxt;
                        end
                    end else if (w_tmo_hit) begin
                        r_fail  <= 1'b1;
                        r_state <= S_CMD;
                        r_valid <= 1'b1;
                        r_cmd   <= CMD_STOP;
                        r_data  <= 8'h00;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                S_RETRY: begin
                    if (r_gap == GAP_LAST) begin
                        r_try   <= r_try + 3'd1;
                        r_fail  <= 1'b0;
                        r_state <= S_CMD;
                        r_valid <= 1'b1;
                        r_cmd   <= CMD_START;
                        r_data  <= 8'h00;
                    end else begin
                        r_gap <= r_gap + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign m_valid  = r_valid;
    assign m_cmd    = r_cmd;
    assign m_data   = r_data;
    assign busy     = r_busy;
    assign pending  = r_pending;
    assign tx_done  = r_tx_done;
    assign tx_error = r_tx_error;
    assign try_cnt  = r_try;

endmodule
